// File: rtl/jump_table_pkg.sv
// Shared constants, state encoding and frame parity helper for the jump-table loader.
// Frame length depends on macro JT_PARITY_CHECK_EN (adds one even-parity bit).
package jump_table_pkg;

   localparam int ENTRY_W   = 5;
   localparam int N_ENTRIES = 5;
   localparam int DATA_BITS = ENTRY_W * N_ENTRIES;
`ifdef JT_PARITY_CHECK_EN
   localparam int PAR_BITS  = 1;
`else
   localparam int PAR_BITS  = 0;
`endif
   localparam int FRAME_BITS = DATA_BITS + PAR_BITS;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } jt_state_e;

   // Even parity holds when the XOR over data bits and the parity bit is zero.
   function automatic logic frame_parity_ok(input logic [FRAME_BITS-1:0] frame);
      return ~(^frame);
   endfunction

endpackage

// File: rtl/jt_shift_reg.sv
// Serial shadow register with saturating bit counter; bits enter at the LSB so
// the first received bit ends up in the MSB.
module jt_shift_reg #(
   parameter int WIDTH = 25,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             sdata,
   output logic [WIDTH-1:0] shadow,
   output logic [CNT_W-1:0] count,
   output logic             full
);

   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_s;

   assign full_s = (count_q == CNT_W'(WIDTH));

   // Clear has priority; shifting stops once the frame is complete so the count never wraps.
   always_comb begin
      shadow_d = shadow_q;
      count_d  = count_q;
      if (clear) begin
         shadow_d = '0;
         count_d  = '0;
      end else if (shift_en && !full_s) begin
         shadow_d = {shadow_q[WIDTH-2:0], sdata};
         count_d  = count_q + CNT_W'(1);
      end else begin
         shadow_d = shadow_q;
         count_d  = count_q;
      end
   end

   // Shadow and counter state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         count_q  <= '0;
      end else begin
         shadow_q <= shadow_d;
         count_q  <= count_d;
      end
   end

   assign shadow = shadow_q;
   assign count  = count_q;
   assign full   = full_s;

endmodule

// File: rtl/jump_table_loader.sv
// Serially loads a five-entry jump table and commits it atomically once a full frame arrives.
// Optional even-parity frame check is enabled by defining JT_PARITY_CHECK_EN.
module jump_table_loader #(
   parameter int ENTRY_W   = jump_table_pkg::ENTRY_W,
   parameter int N_ENTRIES = jump_table_pkg::N_ENTRIES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               sdata,
   input  logic               sstrobe,
   output logic [ENTRY_W-1:0] jump1,
   output logic [ENTRY_W-1:0] jump2,
   output logic [ENTRY_W-1:0] jump3,
   output logic [ENTRY_W-1:0] jump4,
   output logic [ENTRY_W-1:0] jump5,
   output logic               ok,
   output logic               busy,
   output logic               err
);

   import jump_table_pkg::*;

   localparam int DATA_LEN  = ENTRY_W * N_ENTRIES;
   localparam int FRAME_LEN = DATA_LEN + PAR_BITS;
   localparam int CNT_LEN   = $clog2(FRAME_LEN + 1);

   logic [1:0]           rst_sync_q;
   logic                 rst_n_s;
   jt_state_e            state_q, state_d;
   logic                 ok_q, ok_d;
   logic                 busy_q, busy_d;
   logic                 err_q, err_d;
   logic [ENTRY_W-1:0]   jump_q [N_ENTRIES];
   logic [ENTRY_W-1:0]   jump_d [N_ENTRIES];
   logic                 commit_s;
   logic                 clear_s;
   logic                 shift_en_s;
   logic [FRAME_LEN-1:0] shadow_s;
   logic [CNT_LEN-1:0]   count_s;
   logic                 full_s;
   logic [DATA_LEN-1:0]  data_s;

   // Reset asserts immediately but releases only after two clock edges.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_s = rst_sync_q[1];

   jt_shift_reg #(
      .WIDTH (FRAME_LEN),
      .CNT_W (CNT_LEN)
   ) u_shift (
      .clk      (clk),
      .rst_n    (rst_n_s),
      .clear    (clear_s),
      .shift_en (shift_en_s),
      .sdata    (sdata),
      .shadow   (shadow_s),
      .count    (count_s),
      .full     (full_s)
   );

   // Table data sits in the top bits; the parity bit, when present, is the LSB.
   assign data_s = shadow_s[FRAME_LEN-1 -: DATA_LEN];

   // Next-state and control: start always wins over a same-cycle strobe.
   always_comb begin
      state_d    = state_q;
      ok_d       = ok_q;
      err_d      = err_q;
      commit_s   = 1'b0;
      clear_s    = 1'b0;
      shift_en_s = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = LOAD;
               ok_d    = 1'b0;
               err_d   = 1'b0;
               clear_s = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         LOAD: begin
            if (start) begin
               clear_s = 1'b1;
            end else if (full_s) begin
`ifdef JT_PARITY_CHECK_EN
               if (frame_parity_ok(shadow_s)) begin
                  commit_s = 1'b1;
                  ok_d     = 1'b1;
                  state_d  = DONE;
               end else begin
                  err_d    = 1'b1;
                  ok_d     = 1'b0;
                  state_d  = IDLE;
               end
`else
               commit_s = 1'b1;
               ok_d     = 1'b1;
               state_d  = DONE;
`endif
            end else begin
               shift_en_s = sstrobe;
            end
         end
         default: begin
            state_d = IDLE;
            ok_d    = 1'b0;
            err_d   = 1'b0;
         end
      endcase
      busy_d = (state_d == LOAD);
   end

   // Committed table only changes on a successful commit; entry 0 takes the first bits.
   always_comb begin
      for (int i = 0; i < N_ENTRIES; i++) begin
         jump_d[i] = jump_q[i];
         if (commit_s) begin
            jump_d[i] = data_s[DATA_LEN-1-i*ENTRY_W -: ENTRY_W];
         end else begin
            jump_d[i] = jump_q[i];
         end
      end
   end

   // Control and committed-table registers.
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         state_q <= IDLE;
         ok_q    <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < N_ENTRIES; i++) begin
            jump_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         ok_q    <= ok_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         for (int i = 0; i < N_ENTRIES; i++) begin
            jump_q[i] <= jump_d[i];
         end
      end
   end

   assign jump1 = jump_q[0];
   assign jump2 = jump_q[1];
   assign jump3 = jump_q[2];
   assign jump4 = jump_q[3];
   assign jump5 = jump_q[4];
   assign ok    = ok_q;
   assign busy  = busy_q;
   assign err   = err_q;

endmodule
